// File: rtl/pong_pkg.sv
// Shared constants, FSM states and frame layout for the PmodJSTK responder.
package pong_pkg;

   localparam int JSTK_FRAME_BYTES   = 5;
   localparam int JSTK_FRAME_BITS    = 40;
   localparam int JSTK_LED_VALID_BIT = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } jstk_state_t;

   // Byte order X lo, X hi, Y lo, Y hi, buttons; MSB of the vector goes out first.
   function automatic logic [JSTK_FRAME_BITS-1:0] jstk_frame(input logic [9:0] x,
                                                             input logic [9:0] y,
                                                             input logic [2:0] b);
      return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
   endfunction

endpackage

// File: rtl/pmod_jstk_responder_sync_edge.sv
// N-stage input synchroniser with rising/falling edge detect on the last stage.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_reg;
   logic              prev_reg;

   // Clearing to 0 means a pin already low at reset release never yields a fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_reg <= '0;
         prev_reg  <= 1'b0;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], d};
         prev_reg  <= chain_reg[STAGES-1];
      end
   end

   assign level = chain_reg[STAGES-1];
   assign rise  = chain_reg[STAGES-1] & ~prev_reg;
   assign fall  = ~chain_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/pmod_jstk_responder.sv
// SPI mode-0 slave emulating one PmodJSTK: returns a 5-byte position/button
// frame and captures the master's LED command byte.
module pmod_jstk_responder
   import pong_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BYTES = 5
) (
   input  logic       clk50M,
   input  logic       reset,
   input  logic       cs,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic [2:0] buttons,
   output logic [1:0] led,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [5:0] LAST_BIT = 6'(FRAME_BYTES * 8);

   logic cs_level, cs_rise, cs_fall;
   logic sck_rise, sck_fall, sck_level_unused;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
      .clk(clk50M), .reset(reset), .d(cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk50M), .reset(reset), .d(sck),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
      .clk(clk50M), .reset(reset), .d(mosi),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   jstk_state_t                state_reg;
   logic [JSTK_FRAME_BITS-1:0] tx_reg;
   logic [7:0]                 rx_reg;
   logic [5:0]                 bit_cnt_reg;
   logic                       cs_pend_reg;
   logic [JSTK_FRAME_BITS-1:0] snapshot;

   assign snapshot = jstk_frame(x_pos, y_pos, buttons);

   always_ff @(posedge clk50M) begin
      if (reset) begin
         state_reg   <= IDLE;
         tx_reg      <= '0;
         rx_reg      <= '0;
         bit_cnt_reg <= '0;
         cs_pend_reg <= 1'b0;
         miso        <= 1'b0;
         led         <= 2'b00;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // A cs fall seen during DONE is remembered so IDLE can still start the frame.
         if (cs_fall)
            cs_pend_reg <= 1'b1;
         else if (cs_rise)
            cs_pend_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (cs_pend_reg && !cs_level) begin
                  cs_pend_reg <= 1'b0;
                  state_reg   <= LOAD;
               end
            end
            LOAD: begin
               tx_reg      <= snapshot;
               miso        <= snapshot[JSTK_FRAME_BITS-1];
               rx_reg      <= '0;
               bit_cnt_reg <= '0;
               busy        <= 1'b1;
               state_reg   <= SHIFT;
            end
            SHIFT: begin
               if (cs_rise) begin
                  state_reg <= DONE;
               end else begin
                  if (sck_rise) begin
                     // Only the command byte is kept; later bits must not push it out.
                     if (bit_cnt_reg < 6'd8)
                        rx_reg <= {rx_reg[6:0], mosi_level};
                     if (bit_cnt_reg != LAST_BIT)
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                  end
                  if (sck_fall) begin
                     tx_reg <= {tx_reg[JSTK_FRAME_BITS-2:0], 1'b0};
                     miso   <= tx_reg[JSTK_FRAME_BITS-2];
                  end
               end
            end
            DONE: begin
               if (bit_cnt_reg == LAST_BIT) begin
                  frame_done <= 1'b1;
                  if (rx_reg[JSTK_LED_VALID_BIT])
                     led <= rx_reg[1:0];
               end
               busy      <= 1'b0;
               miso      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Bench: SPI master driving the responder, checked against a frame/LED model.
module tb_pmod_jstk_responder;

   logic       clk50M = 1'b0;
   logic       reset = 1'b1;
   logic       cs = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic       miso;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic [2:0] buttons = '0;
   logic [1:0] led;
   logic       busy;
   logic       frame_done;

   int tests = 0;
   int failed = 0;
   int done_cycles = 0;
   int done_pulses = 0;
   logic fd_prev = 1'b0;
   logic [1:0] led_model = 2'b00;

   localparam int HALF = 25;   // 1 MHz sck at 50 MHz clk

   pmod_jstk_responder #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
      .clk50M(clk50M), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi),
      .miso(miso), .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
      .led(led), .busy(busy), .frame_done(frame_done)
   );

   always #10 clk50M = ~clk50M;

   always @(posedge clk50M) begin
      fd_prev <= frame_done;
      if (frame_done) done_cycles <= done_cycles + 1;
      if (frame_done && !fd_prev) done_pulses <= done_pulses + 1;
   end

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] b;
      logic [7:0] cmd;
      int         nbits;
      bit         exp_done;
      logic [1:0] exp_led;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   // One SPI transaction; change_bit/reset_bit < 0 disables those events.
   task automatic run_frame(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic [2:0] b, input logic [7:0] cmd, input int nbits,
                            input int change_bit, input int reset_bit,
                            input bit exp_done, input logic [1:0] exp_led);
      logic [7:0]  eb [5];
      logic [63:0] got_v;
      logic [63:0] exp_v;
      logic        ebit;
      bit          reset_hit;
      int          c0, p0;
      eb[0] = x[7:0];
      eb[1] = {6'b0, x[9:8]};
      eb[2] = y[7:0];
      eb[3] = {6'b0, y[9:8]};
      eb[4] = {5'b0, b};
      got_v = '0;
      exp_v = '0;
      reset_hit = 0;
      x_pos = x; y_pos = y; buttons = b;
      c0 = done_cycles; p0 = done_pulses;
      wait_clk(1);
      cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 8) ? cmd[7 - i] : 1'($urandom_range(0, 1));
         wait_clk(HALF);
         sck = 1'b1;
         got_v[63 - i] = miso;
         if (reset_hit || i >= 40) ebit = 1'b0;
         else ebit = eb[i / 8][7 - (i % 8)];
         exp_v[63 - i] = ebit;
         if (i == 0) check({tag, " busy_in_frame"}, 64'(busy), 64'd1);
         if (i + 1 == change_bit) x_pos = 10'h000;
         if (i + 1 == reset_bit) begin
            reset = 1'b1;
            wait_clk(1);
            reset = 1'b0;
            wait_clk(2);
            check({tag, " reset_outputs"}, 64'({miso, busy, led, frame_done}), 64'd0);
            reset_hit = 1;
            wait_clk(HALF - 3);
         end else begin
            wait_clk(HALF);
         end
         sck = 1'b0;
      end
      wait_clk(HALF);
      cs = 1'b1;
      wait_clk(20);
      check({tag, " miso_bits"}, got_v, exp_v);
      check({tag, " done_pulses"}, 64'(done_pulses - p0), 64'(exp_done));
      check({tag, " done_width"}, 64'(done_cycles - c0), 64'(exp_done));
      check({tag, " led"}, 64'(led), 64'(exp_led));
      check({tag, " busy_after"}, 64'({busy, miso}), 64'd0);
      $display("[TB] %s x=%h y=%h b=%b cmd=%h bits=%0d miso=%h led=%b", tag, x, y, b, cmd,
               nbits, got_v, led);
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{x:10'h2A5, y:10'h13C, b:3'b101, cmd:8'h81, nbits:40, exp_done:1, exp_led:2'b01};
      vecs[1] = '{x:10'h2A5, y:10'h13C, b:3'b101, cmd:8'h03, nbits:40, exp_done:1, exp_led:2'b01};
      vecs[2] = '{x:10'h3FF, y:10'h000, b:3'b111, cmd:8'hFE, nbits:40, exp_done:1, exp_led:2'b10};
      vecs[3] = '{x:10'h000, y:10'h3FF, b:3'b010, cmd:8'h83, nbits:42, exp_done:1, exp_led:2'b11};

      wait_clk(5);
      check("reset_state", 64'({miso, busy, led, frame_done}), 64'd0);
      reset = 1'b0;
      wait_clk(10);
      check("idle_after_reset", 64'({miso, busy, led, frame_done}), 64'd0);

      for (int k = 0; k < 4; k++) begin
         run_frame($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].b, vecs[k].cmd,
                   vecs[k].nbits, -1, -1, vecs[k].exp_done, vecs[k].exp_led);
         led_model = vecs[k].exp_led;
      end

      // Hand-written corner sequences.
      run_frame("set_led01", 10'h2A5, 10'h13C, 3'b101, 8'h81, 40, -1, -1, 1, 2'b01);
      run_frame("x_change", 10'h2A5, 10'h13C, 3'b101, 8'h00, 40, 3, -1, 1, 2'b01);
      run_frame("abort17", 10'h155, 10'h0AA, 3'b001, 8'h82, 17, -1, -1, 0, 2'b01);
      run_frame("after_abort", 10'h123, 10'h3FF, 3'b010, 8'h00, 40, -1, -1, 1, 2'b01);
      run_frame("pulses45", 10'h1C3, 10'h2E7, 3'b100, 8'h82, 45, -1, -1, 1, 2'b10);
      run_frame("reset20", 10'h2A5, 10'h13C, 3'b101, 8'h81, 40, -1, 20, 0, 2'b00);
      run_frame("after_reset", 10'h0F0, 10'h30F, 3'b011, 8'h83, 40, -1, -1, 1, 2'b11);
      led_model = 2'b11;

      // Randomized frames against the protocol model.
      for (int r = 0; r < 20; r++) begin
         logic [9:0] rx, ry;
         logic [2:0] rb;
         logic [7:0] rc;
         int         nb;
         bit         full;
         rx = 10'($urandom);
         ry = 10'($urandom);
         rb = 3'($urandom);
         rc = 8'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 39) : $urandom_range(40, 44);
         full = (nb >= 40);
         if (full && rc[7]) led_model = rc[1:0];
         run_frame($sformatf("rand%0d", r), rx, ry, rb, rc, nb, -1, -1, full, led_model);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
